// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: address/data phase ownership tracking, locked transfers, bus muxing.
// Define ARB_ROUND_ROBIN_EN to alternate between simultaneous requesters instead of fixed priority.
module ahb_arbiter #(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_hbusreq,
  input  logic        m0_hlock,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hgrant,
  output logic        m0_hready,
  output logic [1:0]  m0_hresp,
  output logic [31:0] m0_hrdata,

  input  logic        m1_hbusreq,
  input  logic        m1_hlock,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hgrant,
  output logic        m1_hready,
  output logic [1:0]  m1_hresp,
  output logic [31:0] m1_hrdata,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  output logic        HMASTER
);

  localparam logic DefMaster = (DEFAULT_MASTER != 0);
  localparam logic [1:0] RespOkay = 2'b00;

  logic hmaster_q;
  logic dmaster_q;
  logic dvalid_q;
  logic lock_q;
  logic next_owner;
  logic owner_hlock;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
`endif

  // Next address-phase owner.
  always_comb begin
    next_owner = DefMaster;
    if (m0_hbusreq && m1_hbusreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      next_owner = ~last_q;
`else
      next_owner = 1'b1;
`endif
    end else if (m1_hbusreq) begin
      next_owner = 1'b1;
    end else if (m0_hbusreq) begin
      next_owner = 1'b0;
    end
  end

  assign owner_hlock = hmaster_q ? m1_hlock : m0_hlock;

  // Everything advances only on completed transfers; HREADY low freezes the arbiter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hmaster_q <= DefMaster;
      dmaster_q <= 1'b0;
      dvalid_q  <= 1'b0;
      lock_q    <= 1'b0;
    end else if (HREADY) begin
      dmaster_q <= hmaster_q;
      dvalid_q  <= HTRANS[1];
      lock_q    <= owner_hlock;
      if (!lock_q) begin
        hmaster_q <= next_owner;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b0;
    end else if (HREADY && !lock_q && (next_owner != hmaster_q)) begin
      last_q <= next_owner;
    end
  end
`endif

  assign m0_hgrant = (hmaster_q == 1'b0);
  assign m1_hgrant = (hmaster_q == 1'b1);
  assign HMASTER   = hmaster_q;

  // Address phase follows the address owner, write data follows the data owner.
  always_comb begin
    HADDR  = m0_haddr;
    HTRANS = m0_htrans;
    HWRITE = m0_hwrite;
    HSIZE  = m0_hsize;
    if (hmaster_q) begin
      HADDR  = m1_haddr;
      HTRANS = m1_htrans;
      HWRITE = m1_hwrite;
      HSIZE  = m1_hsize;
    end
  end

  assign HWDATA = dmaster_q ? m1_hwdata : m0_hwdata;

  // Only the master owning an active data phase sees the slave's ready/response.
  always_comb begin
    m0_hready = 1'b0;
    m1_hready = 1'b0;
    m0_hresp  = RespOkay;
    m1_hresp  = RespOkay;
    if (dvalid_q) begin
      if (dmaster_q) begin
        m1_hready = HREADY;
        m1_hresp  = HRESP;
      end else begin
        m0_hready = HREADY;
        m0_hresp  = HRESP;
      end
    end
  end

  assign m0_hrdata = HRDATA;
  assign m1_hrdata = HRDATA;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Randomized scoreboard bench for ahb_arbiter against a transaction-level ownership model.
module tb_ahb_arbiter;

  localparam int DEF = 0;
  localparam int NumCycles = 2000;

  logic        clk;
  logic        reset;
  logic        m0_hbusreq, m0_hlock, m0_hwrite, m0_hgrant, m0_hready;
  logic [31:0] m0_haddr, m0_hwdata, m0_hrdata;
  logic [1:0]  m0_htrans, m0_hresp;
  logic [2:0]  m0_hsize;
  logic        m1_hbusreq, m1_hlock, m1_hwrite, m1_hgrant, m1_hready;
  logic [31:0] m1_haddr, m1_hwdata, m1_hrdata;
  logic [1:0]  m1_htrans, m1_hresp;
  logic [2:0]  m1_hsize;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY, HMASTER;
  logic [2:0]  HSIZE;

  ahb_arbiter #(.DEFAULT_MASTER(DEF)) dut (
    .clk(clk), .reset(reset),
    .m0_hbusreq(m0_hbusreq), .m0_hlock(m0_hlock), .m0_haddr(m0_haddr),
    .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hwdata(m0_hwdata), .m0_hgrant(m0_hgrant), .m0_hready(m0_hready),
    .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
    .m1_hbusreq(m1_hbusreq), .m1_hlock(m1_hlock), .m1_haddr(m1_haddr),
    .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hwdata(m1_hwdata), .m1_hgrant(m1_hgrant), .m1_hready(m1_hready),
    .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HMASTER(HMASTER)
  );

  typedef struct packed {
    logic        g0, g1, hm;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        r0, r1;
    logic [1:0]  p0, p1;
    logic [31:0] d0, d1;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: who owns the address phase, who owns the data phase, lock, last winner.
  int own, down, last;
  bit dbusy, locked;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(bit r0, bit r1);
    int reqs[$];
    if (r0) reqs.push_back(0);
    if (r1) reqs.push_back(1);
    if (reqs.size() == 0) return DEF;
    if (reqs.size() == 1) return reqs[0];
`ifdef ARB_ROUND_ROBIN_EN
    return 1 - last;
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    own = DEF; down = 0; last = 0; dbusy = 0; locked = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  lk, active;
    if (!HREADY) return;
    lk     = (own == 1) ? m1_hlock : m0_hlock;
    active = ((own == 1) ? m1_htrans : m0_htrans) >= 2'd2;
    nxt    = locked ? own : pick(m0_hbusreq, m1_hbusreq);
    if (nxt != own) last = nxt;
    down   = own;
    dbusy  = active;
    locked = lk;
    own    = nxt;
  endtask

  function automatic obs_t predict();
    obs_t e;
    bit   sel1 = (own == 1);
    e.g0     = !sel1;
    e.g1     = sel1;
    e.hm     = sel1;
    e.haddr  = sel1 ? m1_haddr  : m0_haddr;
    e.htrans = sel1 ? m1_htrans : m0_htrans;
    e.hwrite = sel1 ? m1_hwrite : m0_hwrite;
    e.hsize  = sel1 ? m1_hsize  : m0_hsize;
    e.hwdata = (down == 1) ? m1_hwdata : m0_hwdata;
    e.r0     = (dbusy && down == 0) ? HREADY : 1'b0;
    e.r1     = (dbusy && down == 1) ? HREADY : 1'b0;
    e.p0     = (dbusy && down == 0) ? HRESP : 2'b00;
    e.p1     = (dbusy && down == 1) ? HRESP : 2'b00;
    e.d0     = HRDATA;
    e.d1     = HRDATA;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a = '{m0_hgrant, m1_hgrant, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
          m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hrdata, m1_hrdata};
    return a;
  endfunction

  task automatic drive_random();
    m0_hbusreq = 1'($urandom_range(0, 1));
    m1_hbusreq = 1'($urandom_range(0, 1));
    m0_hlock   = ($urandom_range(0, 4) == 0);
    m1_hlock   = ($urandom_range(0, 4) == 0);
    m0_haddr   = $urandom;
    m1_haddr   = $urandom;
    m0_htrans  = 2'($urandom_range(0, 3));
    m1_htrans  = 2'($urandom_range(0, 3));
    m0_hwrite  = 1'($urandom_range(0, 1));
    m1_hwrite  = 1'($urandom_range(0, 1));
    m0_hsize   = 3'($urandom_range(0, 7));
    m1_hsize   = 3'($urandom_range(0, 7));
    m0_hwdata  = $urandom;
    m1_hwdata  = $urandom;
    HRDATA     = $urandom;
    HREADY     = ($urandom_range(0, 3) != 0);
    HRESP      = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the oldest prediction.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec%0d outputs: got %h expected %h", n_vec, a, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive_random();
    model_reset();
    for (int i = 0; i < NumCycles; i++) begin
      @(posedge clk);
      if (reset) model_step();
      #1;
      drive_random();
      if (i >= 600 && i < 660) begin
        // Both masters request continuously with no stalls or locks.
        m0_hbusreq = 1'b1; m1_hbusreq = 1'b1;
        m0_hlock = 1'b0; m1_hlock = 1'b0;
        HREADY = 1'b1;
      end
      if (i >= 1190 && i < 1200) begin
        // Set up an m1 write data phase to be cut by reset.
        m0_hbusreq = 1'b0; m1_hbusreq = 1'b1; m1_hlock = 1'b0;
        m1_htrans = 2'b10; m1_hwrite = 1'b1; HREADY = 1'b1;
      end
      if (i < 3 || (i >= 1200 && i < 1203)) reset = 1'b0;
      else reset = 1'b1;
      if (!reset) model_reset();
      exp_q.push_back(predict());
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
